// File: rtl/ifu_if.sv
// Fetch-side bus bundle: AR/R read channel toward memory and the
// instruction valid/ready channel toward the decoder.
interface ifu_if #(
    parameter int PC_W   = 32,
    parameter int INST_W = 32
);
    logic [PC_W-1:0]   araddr_o;
    logic              arvalid_o;
    logic              arready_i;
    logic [INST_W-1:0] rdata_i;
    logic [1:0]        rresp_i;
    logic              rvalid_i;
    logic              rready_o;
    logic [INST_W-1:0] inst_o;
    logic [PC_W-1:0]   inst_pc_o;
    logic [1:0]        inst_fault_o;
    logic              inst_valid_o;
    logic              inst_ready_i;

    modport master (
        output araddr_o, arvalid_o, rready_o,
        output inst_o, inst_pc_o, inst_fault_o, inst_valid_o,
        input  arready_i, rdata_i, rresp_i, rvalid_i, inst_ready_i
    );

    modport slave (
        input  araddr_o, arvalid_o, rready_o,
        input  inst_o, inst_pc_o, inst_fault_o, inst_valid_o,
        output arready_i, rdata_i, rresp_i, rvalid_i, inst_ready_i
    );
endinterface

// File: rtl/ifu.sv
// Instruction fetch unit: one outstanding AR/R read per committed PC,
// result handed to the decoder with a fault code.
module ifu #(
    parameter int PC_W    = 32,
    parameter int INST_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [PC_W-1:0] pc_i,
    input  logic            wb_en_i,
    ifu_if.master           bus
);

    typedef enum logic [1:0] {IDLE, AR, R, OUT} state_e;
    typedef enum logic [1:0] {
        F_OK       = 2'b00,
        F_MISALIGN = 2'b01,
        F_BUS      = 2'b10,
        F_TIMEOUT  = 2'b11
    } fault_e;

    localparam bit         TIMER_EN   = (TIMEOUT != 0);
    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

    state_e            state_q, state_d;
    fault_e            fault_q, fault_d;
    logic              pend_q, pend_d;
    logic [PC_W-1:0]   addr_q, addr_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic [7:0]        timer_q, timer_d;
    logic              arvalid_q, rready_q, valid_q;
    logic              expired;

    // >= rather than == so an AR handshake on the last allowed cycle still times out in R.
    assign expired = TIMER_EN && (timer_q >= TIMER_LAST);

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d = state_q;
        pend_d  = pend_q | wb_en_i;
        addr_d  = addr_q;
        inst_d  = inst_q;
        fault_d = fault_q;
        timer_d = timer_q;
        unique case (state_q)
            IDLE: begin
                if (pend_q) begin
                    // A strobe in this very cycle keeps pend set: pc_i moves next cycle.
                    pend_d = wb_en_i;
                    addr_d = pc_i;
                    inst_d = '0;
                    if (pc_i[1:0] != 2'b00) begin
                        fault_d = F_MISALIGN;
                        state_d = OUT;
                    end else begin
                        fault_d = F_OK;
                        timer_d = '0;
                        state_d = AR;
                    end
                end
            end
            AR: begin
                timer_d = timer_q + 8'd1;
                if (bus.arready_i) begin
                    state_d = R;
                end else if (expired) begin
                    inst_d  = '0;
                    fault_d = F_TIMEOUT;
                    state_d = OUT;
                end
            end
            R: begin
                timer_d = timer_q + 8'd1;
                if (bus.rvalid_i) begin
                    inst_d  = bus.rdata_i;
                    fault_d = (bus.rresp_i == 2'b00) ? F_OK : F_BUS;
                    state_d = OUT;
                end else if (expired) begin
                    inst_d  = '0;
                    fault_d = F_TIMEOUT;
                    state_d = OUT;
                end
            end
            OUT: begin
                if (bus.inst_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= IDLE;
            pend_q    <= 1'b1;
            addr_q    <= '0;
            inst_q    <= '0;
            fault_q   <= F_OK;
            timer_q   <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            addr_q    <= addr_d;
            inst_q    <= inst_d;
            fault_q   <= fault_d;
            timer_q   <= timer_d;
            arvalid_q <= (state_d == AR);
            rready_q  <= (state_d == R);
            valid_q   <= (state_d == OUT);
        end
    end

    assign bus.araddr_o     = addr_q;
    assign bus.arvalid_o    = arvalid_q;
    assign bus.rready_o     = rready_q;
    assign bus.inst_o       = inst_q;
    assign bus.inst_pc_o    = addr_q;
    assign bus.inst_fault_o = fault_q;
    assign bus.inst_valid_o = valid_q;

endmodule

// File: tb/tb_ifu.sv
// Scoreboard bench for ifu: directed fetches push expected results,
// monitors pop and compare whenever a DUT presents an instruction.
module tb_ifu;

    localparam int PC_W   = 32;
    localparam int INST_W = 32;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] pc_i, pc_t;
    logic        wb_en_i, wb_en_t;

    ifu_if #(.PC_W(PC_W), .INST_W(INST_W)) m ();
    ifu_if #(.PC_W(PC_W), .INST_W(INST_W)) t ();

    ifu #(.PC_W(PC_W), .INST_W(INST_W), .TIMEOUT(255)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .pc_i(pc_i), .wb_en_i(wb_en_i), .bus(m.master)
    );

    // Second copy with a short timeout and a slave that never accepts the address.
    ifu #(.PC_W(PC_W), .INST_W(INST_W), .TIMEOUT(8)) dut_t (
        .clk_i(clk_i), .rst_i(rst_i), .pc_i(pc_t), .wb_en_i(wb_en_t), .bus(t.master)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [1:0]  fault;
    } exp_t;

    exp_t q_m[$];
    exp_t q_t[$];
    int   total = 0;
    int   bad   = 0;

    int          ar_delay  = 0;
    int          r_delay   = 0;
    logic [31:0] rdata_val = 32'h0;
    logic [1:0]  rresp_val = 2'b00;
    int          ar_hs     = 0;
    int          ar_cycles = 0;
    int          t_ar_cycles = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_bound(input string name);
        total++;
        bad++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    function automatic exp_t mk(input logic [31:0] inst, input logic [31:0] pc, input logic [1:0] fault);
        exp_t e;
        e.inst  = inst;
        e.pc    = pc;
        e.fault = fault;
        return e;
    endfunction

    // Memory slave for the main DUT: programmable AR and R delays.
    initial begin
        int          sl;
        int          cnt;
        logic [31:0] addr_seen;
        sl = 0; cnt = 0; addr_seen = '0;
        m.arready_i = 1'b0; m.rvalid_i = 1'b0; m.rdata_i = '0; m.rresp_i = 2'b00;
        forever begin
            @(negedge clk_i);
            if (!rst_i) begin
                sl = 0; cnt = 0;
                m.arready_i = 1'b0; m.rvalid_i = 1'b0;
            end else begin
                if (m.arvalid_o) ar_cycles++;
                case (sl)
                    0: if (m.arvalid_o) begin
                        if (cnt == 0) addr_seen = m.araddr_o;
                        else check("araddr_stable", m.araddr_o, addr_seen);
                        if (cnt == ar_delay) begin
                            m.arready_i = 1'b1;
                            sl = 1;
                        end
                        cnt++;
                    end
                    1: begin
                        m.arready_i = 1'b0;
                        ar_hs++;
                        cnt = 0;
                        if (r_delay == 0) begin
                            m.rvalid_i = 1'b1; m.rdata_i = rdata_val; m.rresp_i = rresp_val;
                            sl = 3;
                        end else begin
                            sl = 2;
                        end
                    end
                    2: begin
                        cnt++;
                        if (cnt == r_delay) begin
                            m.rvalid_i = 1'b1; m.rdata_i = rdata_val; m.rresp_i = rresp_val;
                            sl = 3;
                        end
                    end
                    default: begin
                        m.rvalid_i = 1'b0; m.rdata_i = '0; m.rresp_i = 2'b00;
                        sl = 0; cnt = 0;
                    end
                endcase
            end
        end
    end

    // Main monitor: compare on each new presentation, then demand stability while stalled.
    initial begin
        logic prev;
        exp_t held;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk_i);
            if (!rst_i) begin
                prev = 1'b0;
            end else begin
                if (m.inst_valid_o && !prev) begin
                    held = mk(m.inst_o, m.inst_pc_o, m.inst_fault_o);
                    if (q_m.size() == 0) begin
                        fail_bound("m_unexpected_inst");
                    end else begin
                        e = q_m.pop_front();
                        check("m_inst", m.inst_o, e.inst);
                        check("m_pc", m.inst_pc_o, e.pc);
                        check("m_fault", 32'(m.inst_fault_o), 32'(e.fault));
                    end
                end else if (m.inst_valid_o && prev) begin
                    check("m_hold_inst", m.inst_o, held.inst);
                    check("m_hold_pc", m.inst_pc_o, held.pc);
                    check("m_hold_fault", 32'(m.inst_fault_o), 32'(held.fault));
                end
                prev = m.inst_valid_o;
            end
        end
    end

    // Timeout-DUT monitor.
    initial begin
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk_i);
            if (!rst_i) begin
                prev = 1'b0;
            end else begin
                if (t.arvalid_o) t_ar_cycles++;
                if (t.inst_valid_o && !prev) begin
                    if (q_t.size() == 0) begin
                        fail_bound("t_unexpected_inst");
                    end else begin
                        e = q_t.pop_front();
                        check("t_inst", t.inst_o, e.inst);
                        check("t_pc", t.inst_pc_o, e.pc);
                        check("t_fault", 32'(t.inst_fault_o), 32'(e.fault));
                    end
                end
                prev = t.inst_valid_o;
            end
        end
    end

    task automatic fetch_req(input logic [31:0] new_pc);
        @(negedge clk_i);
        wb_en_i = 1'b1;
        @(negedge clk_i);
        wb_en_i = 1'b0;
        pc_i    = new_pc;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while ((q_m.size() != 0 || q_t.size() != 0 || m.inst_valid_o || t.inst_valid_o) && n < 200);
        if (n >= 200) fail_bound(name);
        @(negedge clk_i);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_arvalid"}, 32'(m.arvalid_o), 0);
        check({tag, "_rready"}, 32'(m.rready_o), 0);
        check({tag, "_valid"}, 32'(m.inst_valid_o), 0);
        check({tag, "_araddr"}, m.araddr_o, 0);
        check({tag, "_inst"}, m.inst_o, 0);
        check({tag, "_pc"}, m.inst_pc_o, 0);
        check({tag, "_fault"}, 32'(m.inst_fault_o), 0);
    endtask

    initial begin
        int hs0;
        int c0;
        int n;
        rst_i = 1'b0; wb_en_i = 1'b0; wb_en_t = 1'b0;
        pc_i = 32'h8000_0000; pc_t = 32'h8000_0000;
        m.inst_ready_i = 1'b1;
        t.inst_ready_i = 1'b1; t.arready_i = 1'b0; t.rvalid_i = 1'b0;
        t.rdata_i = 32'hcafe_f00d; t.rresp_i = 2'b00;
        rdata_val = 32'h0000_0413; rresp_val = 2'b00; ar_delay = 0; r_delay = 0;

        repeat (3) @(negedge clk_i);
        check_all_zero("rst");

        // Best-case fetch latency from reset release.
        q_m.push_back(mk(32'h0000_0413, 32'h8000_0000, 2'b00));
        q_t.push_back(mk(32'h0, 32'h8000_0000, 2'b11));
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        check("lat_arvalid_c1", 32'(m.arvalid_o), 1);
        @(posedge clk_i); #1;
        check("lat_rready_c2", 32'(m.rready_o), 1);
        check("lat_valid_c2", 32'(m.inst_valid_o), 0);
        @(posedge clk_i); #1;
        check("lat_valid_c3", 32'(m.inst_valid_o), 1);

        // Timeout copy: eight cycles in AR, OUT on the ninth edge.
        repeat (5) @(posedge clk_i);
        #1;
        check("t_valid_c8", 32'(t.inst_valid_o), 0);
        check("t_arvalid_c8", 32'(t.arvalid_o), 1);
        @(posedge clk_i); #1;
        check("t_valid_c9", 32'(t.inst_valid_o), 1);
        check("t_arvalid_c9", 32'(t.arvalid_o), 0);
        wait_idle("wait_first");
        check("t_ar_cycles", t_ar_cycles, 8);
        @(negedge clk_i);
        t.rvalid_i = 1'b1;
        repeat (3) begin
            @(negedge clk_i);
            check("t_late_rready", 32'(t.rready_o), 0);
        end
        t.rvalid_i = 1'b0;

        // Slow slave: one AR handshake, address held throughout.
        ar_delay = 4; r_delay = 3; rdata_val = 32'h00a0_0093;
        hs0 = ar_hs;
        q_m.push_back(mk(32'h00a0_0093, 32'h8000_0100, 2'b00));
        fetch_req(32'h8000_0100);
        wait_idle("wait_slow");
        check("ar_hs_once", ar_hs - hs0, 1);
        ar_delay = 0; r_delay = 0;

        // Decoder stall with a write-back strobe arriving during OUT.
        m.inst_ready_i = 1'b0;
        rdata_val = 32'h1111_1111;
        q_m.push_back(mk(32'h1111_1111, 32'h8000_0200, 2'b00));
        fetch_req(32'h8000_0200);
        n = 0;
        while (!m.inst_valid_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 50) fail_bound("wait_stall_valid");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            check("stall_no_ar", 32'(m.arvalid_o), 0);
            if (i == 1) wb_en_i = 1'b1;
            if (i == 2) begin
                wb_en_i = 1'b0;
                pc_i    = 32'h8000_0204;
            end
        end
        rdata_val = 32'h2222_2222;
        q_m.push_back(mk(32'h2222_2222, 32'h8000_0204, 2'b00));
        m.inst_ready_i = 1'b1;
        wait_idle("wait_stall");

        // Misaligned PC: no bus access, fault two edges after the strobe.
        c0 = ar_cycles;
        q_m.push_back(mk(32'h0, 32'h8000_0002, 2'b01));
        @(negedge clk_i);
        wb_en_i = 1'b1;
        @(negedge clk_i);
        wb_en_i = 1'b0;
        pc_i    = 32'h8000_0002;
        check("mis_valid_early", 32'(m.inst_valid_o), 0);
        @(negedge clk_i);
        check("mis_valid", 32'(m.inst_valid_o), 1);
        wait_idle("wait_mis");
        check("mis_no_ar", ar_cycles - c0, 0);

        // Bus error response.
        rresp_val = 2'b10; rdata_val = 32'hdead_beef;
        q_m.push_back(mk(32'hdead_beef, 32'h8000_0004, 2'b10));
        fetch_req(32'h8000_0004);
        wait_idle("wait_buserr");
        rresp_val = 2'b00;

        // Reset while waiting in R, then a fresh fetch after release.
        r_delay = 20;
        fetch_req(32'h8000_0300);
        n = 0;
        while (!m.rready_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 50) fail_bound("wait_rready");
        #2 rst_i = 1'b0;
        #1 check_all_zero("rstmid");
        r_delay = 0; rdata_val = 32'h3333_3333; pc_i = 32'h8000_0400;
        repeat (2) @(negedge clk_i);
        q_m.push_back(mk(32'h3333_3333, 32'h8000_0400, 2'b00));
        q_t.push_back(mk(32'h0, 32'h8000_0000, 2'b11));
        rst_i = 1'b1;
        wait_idle("wait_after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
